mesi_broad_ctrl: RTL and testbench

- Consumer end of the broadcast FIFO interface. The broadcast-request arbiter writes into it through broad_fifo_wr/broad_addr/broad_type/broad_cpu_id/broad_id and observes broad_fifo_status_full.
- Internally: DEPTH-entry FIFO plus a dispatcher FSM.
- The FSM pops one entry at a time and issues a snoop to every CPU except the originator, then waits for all of them to report done before popping the next entry.

---
 rtl/mesi_broad_ctrl.sv | 119 +++++++++++
 tb/tb_mesi_broad_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mesi_broad_ctrl.sv
// rtl/mesi_broad_ctrl.sv - broadcast FIFO consumer and snoop dispatcher
module mesi_broad_ctrl #(
  parameter int DEPTH   = 4,
  parameter int CPU_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     broad_fifo_wr,
  input  logic [31:0]              broad_addr,
  input  logic [1:0]               broad_type,
  input  logic [1:0]               broad_cpu_id,
  input  logic [6:0]               broad_id,
  output logic                     broad_fifo_status_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CPU_NUM-1:0]       cpu_snoop_valid,
  output logic [31:0]              snoop_addr,
  output logic [1:0]               snoop_type,
  output logic [1:0]               snoop_cpu_id,
  output logic [6:0]               snoop_id,
  input  logic [CPU_NUM-1:0]       cpu_snoop_done,
  output logic                     broad_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [1:0]  cpu;
    logic [6:0]  id;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CPU_NUM-1:0]   pending_q, pending_d;
  state_t               state_q, state_d;
  entry_t               snoop_q, snoop_d;
  entry_t               head;
  logic                 push, pop;

  // Full test uses the pre-edge count only; a same-cycle pop never makes room.
  assign push = broad_fifo_wr && (count_q != CW'(DEPTH));
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  assign broad_fifo_status_full = (count_q == CW'(DEPTH));
  assign fifo_count             = count_q;
  assign cpu_snoop_valid        = pending_q;
  assign broad_busy             = (state_q == WAIT);
  assign snoop_addr             = snoop_q.addr;
  assign snoop_type             = snoop_q.typ;
  assign snoop_cpu_id           = snoop_q.cpu;
  assign snoop_id               = snoop_q.id;

  // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);
  end

  // Dispatcher: pop in IDLE and snoop every CPU but the originator, then wait for all done.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    snoop_d   = snoop_q;
    case (state_q)
      IDLE: begin
        pending_d = '0;
        if (pop) begin
          snoop_d   = head;
          pending_d = {CPU_NUM{1'b1}} & ~(CPU_NUM'(1) << head.cpu);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        pending_d = pending_q & ~cpu_snoop_done;
        if (pending_d == '0) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // Entry storage: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: broad_addr, typ: broad_type,
                                    cpu: broad_cpu_id, id: broad_id};
  end

  // Control state register; reset discards the active and all queued entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      snoop_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      snoop_q   <= snoop_d;
    end
  end

endmodule

// File: tb/tb_mesi_broad_ctrl.sv
// tb/tb_mesi_broad_ctrl.sv - directed self-checking bench for mesi_broad_ctrl
module tb_mesi_broad_ctrl;

  logic        clk;
  logic        rst;
  logic        broad_fifo_wr;
  logic [31:0] broad_addr;
  logic [1:0]  broad_type;
  logic [1:0]  broad_cpu_id;
  logic [6:0]  broad_id;
  logic        broad_fifo_status_full;
  logic [2:0]  fifo_count;
  logic [3:0]  cpu_snoop_valid;
  logic [31:0] snoop_addr;
  logic [1:0]  snoop_type;
  logic [1:0]  snoop_cpu_id;
  logic [6:0]  snoop_id;
  logic [3:0]  cpu_snoop_done;
  logic        broad_busy;

  int checks = 0;
  int errors = 0;

  mesi_broad_ctrl #(.DEPTH(4), .CPU_NUM(4)) dut (
    .clk(clk), .rst(rst),
    .broad_fifo_wr(broad_fifo_wr), .broad_addr(broad_addr), .broad_type(broad_type),
    .broad_cpu_id(broad_cpu_id), .broad_id(broad_id),
    .broad_fifo_status_full(broad_fifo_status_full), .fifo_count(fifo_count),
    .cpu_snoop_valid(cpu_snoop_valid), .snoop_addr(snoop_addr), .snoop_type(snoop_type),
    .snoop_cpu_id(snoop_cpu_id), .snoop_id(snoop_id),
    .cpu_snoop_done(cpu_snoop_done), .broad_busy(broad_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [1:0] t,
                       input logic [1:0] c, input logic [6:0] i);
    broad_fifo_wr = wr;
    broad_addr    = a;
    broad_type    = t;
    broad_cpu_id  = c;
    broad_id      = i;
  endtask

  logic [6:0] exp_ids  [5];
  logic [3:0] exp_mask [5];

  initial begin
    rst = 1'b0;
    cpu_snoop_done = 4'b0;
    drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
    tick();
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_full", 32'(broad_fifo_status_full), 32'd0);
    chk("rst_valid", 32'(cpu_snoop_valid), 32'd0);
    chk("rst_busy", 32'(broad_busy), 32'd0);
    chk("rst_addr", snoop_addr, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single broadcast, done from CPUs 0,1,3 one per cycle
    drive(1'b1, 32'h0000_1000, 2'b01, 2'd2, 7'h05);
    tick();
    drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_valid_before_pop", 32'(cpu_snoop_valid), 32'd0);
    tick();
    chk("t1_valid0", 32'(cpu_snoop_valid), 32'b1011);
    chk("t1_busy0", 32'(broad_busy), 32'd1);
    chk("t1_count0", 32'(fifo_count), 32'd0);
    chk("t1_addr0", snoop_addr, 32'h0000_1000);
    chk("t1_type", 32'(snoop_type), 32'd1);
    chk("t1_cpu", 32'(snoop_cpu_id), 32'd2);
    chk("t1_id", 32'(snoop_id), 32'h05);
    cpu_snoop_done = 4'b0001;
    tick();
    chk("t1_valid1", 32'(cpu_snoop_valid), 32'b1010);
    chk("t1_addr1", snoop_addr, 32'h0000_1000);
    cpu_snoop_done = 4'b0010;
    tick();
    chk("t1_valid2", 32'(cpu_snoop_valid), 32'b1000);
    chk("t1_busy2", 32'(broad_busy), 32'd1);
    cpu_snoop_done = 4'b1000;
    tick();
    chk("t1_valid3", 32'(cpu_snoop_valid), 32'd0);
    chk("t1_busy3", 32'(broad_busy), 32'd0);
    chk("t1_addr3", snoop_addr, 32'h0000_1000);
    cpu_snoop_done = 4'b0;
    tick();
    chk("t1_idle_valid", 32'(cpu_snoop_valid), 32'd0);

    // Back-to-back pushes A..F, no done; F is dropped on full
    drive(1'b1, 32'hA000, 2'd0, 2'd0, 7'h10); tick();
    chk("t2_count_e1", 32'(fifo_count), 32'd1);
    drive(1'b1, 32'hB000, 2'd1, 2'd1, 7'h11); tick();
    chk("t2_count_e2", 32'(fifo_count), 32'd1);
    chk("t2_valid_A", 32'(cpu_snoop_valid), 32'b1110);
    drive(1'b1, 32'hC000, 2'd2, 2'd2, 7'h12); tick();
    chk("t2_count_e3", 32'(fifo_count), 32'd2);
    drive(1'b1, 32'hD000, 2'd3, 2'd3, 7'h13); tick();
    chk("t2_count_e4", 32'(fifo_count), 32'd3);
    chk("t2_full_e4", 32'(broad_fifo_status_full), 32'd0);
    drive(1'b1, 32'hE000, 2'd0, 2'd0, 7'h14); tick();
    chk("t2_count_e5", 32'(fifo_count), 32'd4);
    chk("t2_full_e5", 32'(broad_fifo_status_full), 32'd1);
    drive(1'b1, 32'hF000, 2'd0, 2'd1, 7'h15); tick();
    drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
    chk("t2_count_e6", 32'(fifo_count), 32'd4);
    chk("t2_full_e6", 32'(broad_fifo_status_full), 32'd1);
    chk("t2_id_A", 32'(snoop_id), 32'h10);

    // All pending done at once: one WAIT cycle, one idle cycle, next pop
    cpu_snoop_done = 4'b1111;
    tick();
    chk("t3_valid_idle", 32'(cpu_snoop_valid), 32'd0);
    chk("t3_busy_idle", 32'(broad_busy), 32'd0);
    chk("t3_count_idle", 32'(fifo_count), 32'd4);
    cpu_snoop_done = 4'b0;
    // Push while full in the same cycle as the pop: dropped
    drive(1'b1, 32'h3000, 2'd0, 2'd2, 7'h30);
    tick();
    chk("t4_count_drop", 32'(fifo_count), 32'd3);
    chk("t4_full_drop", 32'(broad_fifo_status_full), 32'd0);
    chk("t3_valid_B", 32'(cpu_snoop_valid), 32'b1101);
    chk("t3_busy_B", 32'(broad_busy), 32'd1);
    drive(1'b1, 32'h1600, 2'd1, 2'd1, 7'h16);
    tick();
    drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
    chk("t4_count_accept", 32'(fifo_count), 32'd4);
    chk("t4_full_accept", 32'(broad_fifo_status_full), 32'd1);

    // Drain in push order: B, C, D, E, G (H and F must never appear)
    exp_ids[0] = 7'h11; exp_mask[0] = 4'b1101;
    exp_ids[1] = 7'h12; exp_mask[1] = 4'b1011;
    exp_ids[2] = 7'h13; exp_mask[2] = 4'b0111;
    exp_ids[3] = 7'h14; exp_mask[3] = 4'b1110;
    exp_ids[4] = 7'h16; exp_mask[4] = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_drain_id%0d", k), 32'(snoop_id), 32'(exp_ids[k]));
      chk($sformatf("t2_drain_mask%0d", k), 32'(cpu_snoop_valid), 32'(exp_mask[k]));
      cpu_snoop_done = 4'b1111;
      tick();
      cpu_snoop_done = 4'b0;
      chk($sformatf("t2_drain_done%0d", k), 32'(cpu_snoop_valid), 32'd0);
      tick();
    end
    chk("t2_drain_empty", 32'(fifo_count), 32'd0);
    chk("t2_drain_idle", 32'(broad_busy), 32'd0);

    // Async reset mid-WAIT with two queued entries
    drive(1'b1, 32'h5000, 2'd1, 2'd0, 7'h20); tick();
    drive(1'b1, 32'h5100, 2'd1, 2'd1, 7'h21); tick();
    drive(1'b1, 32'h5200, 2'd1, 2'd2, 7'h22); tick();
    drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
    chk("t5_pre_count", 32'(fifo_count), 32'd2);
    chk("t5_pre_busy", 32'(broad_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(cpu_snoop_valid), 32'd0);
    chk("t5_rst_busy", 32'(broad_busy), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_addr", snoop_addr, 32'd0);
    chk("t5_rst_id", 32'(snoop_id), 32'd0);
    #2 rst = 1'b1;
    cpu_snoop_done = 4'b1111;
    tick();
    tick();
    cpu_snoop_done = 4'b0;
    chk("t5_post_valid", 32'(cpu_snoop_valid), 32'd0);
    chk("t5_post_count", 32'(fifo_count), 32'd0);
    chk("t5_post_busy", 32'(broad_busy), 32'd0);
    tick();

    // Wrap: ten push/complete rounds through a 4-entry FIFO
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i) * 32'h10, 2'(i), 2'(i % 4), 7'(i));
      tick();
      drive(1'b0, 32'h0, 2'b0, 2'b0, 7'h0);
      chk($sformatf("t6_count%0d", i), 32'(fifo_count), 32'd1);
      tick();
      chk($sformatf("t6_id%0d", i), 32'(snoop_id), 32'(i));
      chk($sformatf("t6_addr%0d", i), snoop_addr, 32'(i) * 32'h10);
      chk($sformatf("t6_mask%0d", i), 32'(cpu_snoop_valid),
          32'(4'b1111 & ~(4'b0001 << (i % 4))));
      cpu_snoop_done = 4'b1111;
      tick();
      cpu_snoop_done = 4'b0;
    end
    chk("t6_end_count", 32'(fifo_count), 32'd0);
    chk("t6_end_valid", 32'(cpu_snoop_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
